// File: rtl/bip_debug_sender.sv
// BIP debug reporter: times a run from start_bip to halt, then streams a snapshot frame into the UART TX FIFO.
// Optional BIP_DEBUG_CHECKSUM_EN appends an XOR checksum byte (bytes 1..6) to the frame.
module bip_debug_sender #(
    parameter int          AB  = 11,
    parameter int          DB  = 16,
    parameter int          CW  = 16,
    parameter logic [7:0]  HDR = 8'hA5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_bip,
    input  logic          halt,
    input  logic [DB-1:0] acc,
    input  logic [AB-1:0] pc,
    input  logic          tx_full,
    output logic [7:0]    w_data,
    output logic          wr_uart,
    output logic          busy,
    output logic          done
);

    // state | meaning
    // IDLE  | waiting for start_bip
    // RUN   | counting cycles until halt
    // SEND  | streaming the latched frame into the TX FIFO
    // DONE  | one-cycle completion pulse
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

`ifdef BIP_DEBUG_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd7;
`else
    localparam logic [2:0] LAST_IDX = 3'd6;
`endif

    localparam logic [CW-1:0] CYC_MAX = '1;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cyc;
    logic [DB-1:0] r_acc;
    logic [AB-1:0] r_pc;
    logic [2:0]    r_idx;

    logic [15:0]   w_acc16;
    logic [15:0]   w_pc16;
    logic [15:0]   w_cyc16;
    logic [7:0]    w_byte;

    assign w_acc16 = 16'(r_acc);
    assign w_pc16  = 16'(r_pc);
    assign w_cyc16 = 16'(r_cyc);

`ifdef BIP_DEBUG_CHECKSUM_EN
    logic [7:0] w_chk;
    assign w_chk = w_acc16[15:8] ^ w_acc16[7:0] ^ w_pc16[15:8] ^ w_pc16[7:0]
                 ^ w_cyc16[15:8] ^ w_cyc16[7:0];
`endif

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            3'd0:    w_byte = HDR;
            3'd1:    w_byte = w_acc16[15:8];
            3'd2:    w_byte = w_acc16[7:0];
            3'd3:    w_byte = w_pc16[15:8];
            3'd4:    w_byte = w_pc16[7:0];
            3'd5:    w_byte = w_cyc16[15:8];
            3'd6:    w_byte = w_cyc16[7:0];
`ifdef BIP_DEBUG_CHECKSUM_EN
            3'd7:    w_byte = w_chk;
`endif
            default: w_byte = 8'h00;
        endcase
    end

    assign wr_uart = (r_state == S_SEND) && !tx_full;
    assign w_data  = wr_uart ? w_byte : 8'h00;
    assign busy    = (r_state == S_RUN) || (r_state == S_SEND);
    assign done    = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cyc   <= '0;
            r_acc   <= '0;
            r_pc    <= '0;
            r_idx   <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_bip) begin
                        r_state <= S_RUN;
                        r_cyc   <= '0;
                    end
                end
                S_RUN: begin
                    // the counter simply freezes on the halt edge and serves as the latched count
                    if (halt) begin
                        r_acc   <= acc;
                        r_pc    <= pc;
                        r_idx   <= 3'd0;
                        r_state <= S_SEND;
                    end else if (r_cyc != CYC_MAX) begin
                        r_cyc <= r_cyc + CW'(1);
                    end
                end
                S_SEND: begin
                    if (wr_uart) begin
                        if (r_idx == LAST_IDX) r_state <= S_DONE;
                        else                   r_idx   <= r_idx + 3'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bip_debug_sender.sv
// Self-checking bench for bip_debug_sender: a CW=16 instance and a CW=4 instance share stimulus;
// written bytes are captured and compared with frames built from the run parameters.
module tb_bip_debug_sender;

`ifdef BIP_DEBUG_CHECKSUM_EN
    localparam int FLEN = 8;
`else
    localparam int FLEN = 7;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_bip = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] acc = 16'h0;
    logic [10:0] pc = 11'h0;
    logic        tx_full = 1'b0;
    logic [7:0]  w_data, w_data2;
    logic        wr_uart, wr2, busy, busy2, done, done2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;
    int viol = 0;
    int wviol = 0;
    logic [7:0] q[$];
    logic [7:0] q2[$];
    int         wc[$];
    logic [7:0] ef[8];

    bip_debug_sender #(.AB(11), .DB(16), .CW(16), .HDR(8'hA5)) dut (
        .clk(clk), .reset(reset), .start_bip(start_bip), .halt(halt), .acc(acc), .pc(pc),
        .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart), .busy(busy), .done(done));

    bip_debug_sender #(.AB(11), .DB(16), .CW(4), .HDR(8'hA5)) dut4 (
        .clk(clk), .reset(reset), .start_bip(start_bip), .halt(halt), .acc(acc), .pc(pc),
        .tx_full(tx_full), .w_data(w_data2), .wr_uart(wr2), .busy(busy2), .done(done2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        if (wr_uart) begin
            q.push_back(w_data);
            wc.push_back(cyc_n);
            if (tx_full) viol++;
        end else if (w_data !== 8'h00) begin
            wviol++;
        end
        if (wr2) q2.push_back(w_data2);
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running at time %0t, expected finish", $time);
        $fatal(1, "timeout");
    end

    // Reference frame: header, acc, pc, saturated cycle count (16-bit MSB first), optional XOR.
    task automatic fill_exp(input logic [15:0] a, input logic [10:0] p, input int n, input int cw);
        int c;
        logic [15:0] p16;
        c   = (n > (1 << cw) - 1) ? (1 << cw) - 1 : n;
        p16 = {5'b0, p};
        ef[0] = 8'hA5;
        ef[1] = a[15:8];
        ef[2] = a[7:0];
        ef[3] = p16[15:8];
        ef[4] = p16[7:0];
        ef[5] = 8'((c / 256) % 256);
        ef[6] = 8'(c % 256);
        ef[7] = ef[1] ^ ef[2] ^ ef[3] ^ ef[4] ^ ef[5] ^ ef[6];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        q.delete();
        q2.delete();
        wc.delete();
    endtask

    task automatic start_run();
        start_bip = 1'b1;
        tick();
        start_bip = 1'b0;
    endtask

    task automatic halt_with(input logic [15:0] a, input logic [10:0] p, input bit also_start);
        acc = a;
        pc = p;
        halt = 1'b1;
        start_bip = also_start;
        tick();
        halt = 1'b0;
        start_bip = 1'b0;
        acc = 16'($urandom);
        pc = 11'($urandom);
    endtask

    task automatic wait_done(input int budget, input bit rand_full, output bit ok, output int dcyc);
        ok = 1'b0;
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (rand_full) tx_full = ($urandom_range(0, 2) == 0);
            tick();
            if (done) begin
                ok = 1'b1;
                dcyc = cyc_n;
                break;
            end
        end
        tx_full = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (wr_uart !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || w_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: wr=%b busy=%b done=%b data=%h want 0/0/0/00",
                     wr_uart, busy, done, w_data);
        end
        tick();
        reset = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (busy !== 1'b0 || q.size() != 0) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy=%b writes=%0d want 0/0", busy, q.size());
        end
    endtask

    task automatic test_basic();
        bit ok;
        int dcyc, hcyc;
        clear_caps();
        start_run();
        repeat (10) tick();
        halt_with(16'h1234, 11'h2A5, 1'b0);
        hcyc = cyc_n;
        wait_done(40, 1'b0, ok, dcyc);
        fill_exp(16'h1234, 11'h2A5, 10, 16);
        n_cmp++;
        if (!ok || q.size() != FLEN) begin
            n_bad++;
            $display("FAIL basic_len: done_seen=%b writes=%0d want 1/%0d", ok, q.size(), FLEN);
        end
        for (int i = 0; i < FLEN && i < q.size(); i++) begin
            n_cmp++;
            if (q[i] !== ef[i]) begin
                n_bad++;
                $display("FAIL basic_byte%0d: got %h want %h", i, q[i], ef[i]);
            end
        end
        if (wc.size() == FLEN) begin
            n_cmp++;
            if (wc[0] != hcyc || wc[FLEN-1] != hcyc + FLEN - 1 || dcyc != wc[FLEN-1] + 1) begin
                n_bad++;
                $display("FAIL basic_timing: first=%0d last=%0d done=%0d want %0d/%0d/%0d",
                         wc[0], wc[FLEN-1], dcyc, hcyc, hcyc + FLEN - 1, hcyc + FLEN);
            end
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_done_pulse: done=%b busy=%b want 0/0", done, busy);
        end
`ifdef BIP_DEBUG_CHECKSUM_EN
        n_cmp++;
        if (q.size() == 8 && q[7] !== 8'h8B) begin
            n_bad++;
            $display("FAIL checksum: got %h want 8b", q[7]);
        end
`endif
    endtask

    task automatic test_backpressure();
        bit ok;
        int dcyc;
        clear_caps();
        start_run();
        repeat (10) tick();
        halt_with(16'h1234, 11'h2A5, 1'b0);
        tick();
        tick();
        tx_full = 1'b1;
        repeat (5) begin
            #1;
            n_cmp++;
            if (wr_uart !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_stall_wr: got %b want 0", wr_uart);
            end
            tick();
        end
        tx_full = 1'b0;
        wait_done(40, 1'b0, ok, dcyc);
        fill_exp(16'h1234, 11'h2A5, 10, 16);
        n_cmp++;
        if (!ok || q.size() != FLEN || viol != 0) begin
            n_bad++;
            $display("FAIL bp_len: done_seen=%b writes=%0d full_writes=%0d want 1/%0d/0",
                     ok, q.size(), viol, FLEN);
        end
        for (int i = 0; i < FLEN && i < q.size(); i++) begin
            n_cmp++;
            if (q[i] !== ef[i]) begin
                n_bad++;
                $display("FAIL bp_byte%0d: got %h want %h", i, q[i], ef[i]);
            end
        end
        tick();
    endtask

    task automatic test_saturation();
        bit ok;
        int dcyc;
        clear_caps();
        start_run();
        repeat (20) tick();
        halt_with(16'hBEEF, 11'h123, 1'b0);
        wait_done(40, 1'b0, ok, dcyc);
        fill_exp(16'hBEEF, 11'h123, 20, 4);
        n_cmp++;
        if (q2.size() != FLEN || q2[5] !== 8'h00 || q2[6] !== 8'h0F) begin
            n_bad++;
            $display("FAIL sat_cw4: writes=%0d cyc=%h%h want %0d/000f", q2.size(),
                     (q2.size() > 6) ? q2[5] : 8'hxx, (q2.size() > 6) ? q2[6] : 8'hxx, FLEN);
        end
        for (int i = 0; i < FLEN && i < q2.size(); i++) begin
            n_cmp++;
            if (q2[i] !== ef[i]) begin
                n_bad++;
                $display("FAIL sat_byte%0d: got %h want %h", i, q2[i], ef[i]);
            end
        end
        tick();
    endtask

    task automatic test_ignored();
        bit ok;
        int dcyc, nq;
        clear_caps();
        halt_with(16'h5555, 11'h055, 1'b0);
        repeat (5) tick();
        n_cmp++;
        if (q.size() != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_halt: writes=%0d busy=%b want 0/0", q.size(), busy);
        end
        start_run();
        repeat (7) tick();
        halt_with(16'hA0C3, 11'h7FF, 1'b0);
        tick();
        start_bip = 1'b1;
        tick();
        start_bip = 1'b0;
        wait_done(40, 1'b0, ok, dcyc);
        fill_exp(16'hA0C3, 11'h7FF, 7, 16);
        n_cmp++;
        if (!ok || q.size() != FLEN) begin
            n_bad++;
            $display("FAIL send_start_len: done_seen=%b writes=%0d want 1/%0d", ok, q.size(), FLEN);
        end
        for (int i = 0; i < FLEN && i < q.size(); i++) begin
            n_cmp++;
            if (q[i] !== ef[i]) begin
                n_bad++;
                $display("FAIL send_start_byte%0d: got %h want %h", i, q[i], ef[i]);
            end
        end
        start_bip = 1'b1;
        tick();
        start_bip = 1'b0;
        nq = q.size();
        repeat (3) tick();
        n_cmp++;
        if (busy !== 1'b0 || q.size() != nq) begin
            n_bad++;
            $display("FAIL done_start_ignored: busy=%b extra_writes=%0d want 0/0", busy, q.size() - nq);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        int dcyc;
        clear_caps();
        start_run();
        repeat (5) tick();
        halt_with(16'h0F0F, 11'h400, 1'b1);
        wait_done(40, 1'b0, ok, dcyc);
        fill_exp(16'h0F0F, 11'h400, 5, 16);
        n_cmp++;
        if (!ok || q.size() != FLEN) begin
            n_bad++;
            $display("FAIL simul_len: done_seen=%b writes=%0d want 1/%0d", ok, q.size(), FLEN);
        end
        for (int i = 0; i < FLEN && i < q.size(); i++) begin
            n_cmp++;
            if (q[i] !== ef[i]) begin
                n_bad++;
                $display("FAIL simul_byte%0d: got %h want %h", i, q[i], ef[i]);
            end
        end
        tick();
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int dcyc, nq;
        clear_caps();
        start_run();
        repeat (9) tick();
        halt_with(16'h7777, 11'h111, 1'b0);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        nq = q.size();
        n_cmp++;
        if (wr_uart !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_out: wr=%b busy=%b done=%b want 0/0/0", wr_uart, busy, done);
        end
        reset = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (q.size() != nq || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_idle: extra_writes=%0d busy=%b want 0/0", q.size() - nq, busy);
        end
        clear_caps();
        start_run();
        repeat (12) tick();
        halt_with(16'hCAFE, 11'h0AB, 1'b0);
        wait_done(40, 1'b0, ok, dcyc);
        fill_exp(16'hCAFE, 11'h0AB, 12, 16);
        n_cmp++;
        if (!ok || q.size() != FLEN) begin
            n_bad++;
            $display("FAIL fresh_len: done_seen=%b writes=%0d want 1/%0d", ok, q.size(), FLEN);
        end
        for (int i = 0; i < FLEN && i < q.size(); i++) begin
            n_cmp++;
            if (q[i] !== ef[i]) begin
                n_bad++;
                $display("FAIL fresh_byte%0d: got %h want %h", i, q[i], ef[i]);
            end
        end
        tick();
    endtask

    task automatic test_random();
        bit ok;
        int dcyc, n;
        logic [15:0] a;
        logic [10:0] p;
        for (int r = 0; r < 8; r++) begin
            clear_caps();
            viol = 0;
            n = $urandom_range(0, 40);
            a = 16'($urandom);
            p = 11'($urandom);
            start_run();
            repeat (n) tick();
            halt_with(a, p, 1'($urandom_range(0, 1)));
            wait_done(200, 1'b1, ok, dcyc);
            fill_exp(a, p, n, 16);
            n_cmp++;
            if (!ok || q.size() != FLEN || viol != 0) begin
                n_bad++;
                $display("FAIL rand%0d_len: done_seen=%b writes=%0d full_writes=%0d want 1/%0d/0",
                         r, ok, q.size(), viol, FLEN);
            end
            for (int i = 0; i < FLEN && i < q.size(); i++) begin
                n_cmp++;
                if (q[i] !== ef[i]) begin
                    n_bad++;
                    $display("FAIL rand%0d_byte%0d: got %h want %h", r, i, q[i], ef[i]);
                end
            end
            fill_exp(a, p, n, 4);
            n_cmp++;
            if (q2.size() != FLEN || q2[6] !== ef[6] || q2[5] !== ef[5]) begin
                n_bad++;
                $display("FAIL rand%0d_cw4: writes=%0d cyc_lo=%h want %0d/%h", r, q2.size(),
                         (q2.size() > 6) ? q2[6] : 8'hxx, FLEN, ef[6]);
            end
            tick();
        end
        n_cmp++;
        if (wviol != 0) begin
            n_bad++;
            $display("FAIL idle_wdata: nonzero w_data without write seen %0d times want 0", wviol);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_saturation();
        test_ignored();
        test_simultaneous();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
